// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score tracker:
//   - bcd_digit_t     : one BCD digit
//   - SEG_0..SEG_9    : active-low seven-segment codes {DP,G,F,E,D,C,B,A}
//   - SEG_BLANK       : all segments off
//   - win_to_bcd()    : converts a decimal threshold into packed BCD (4 digits)
// -----------------------------------------------------------------------------
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Decimal to packed BCD, units digit in bits [3:0].
    function automatic logic [15:0] win_to_bcd(input int value);
        logic [15:0] bcd;
        int          v;
        bcd = 16'h0000;
        v   = value;
        for (int i = 0; i < 4; i++) begin
            bcd[i*4 +: 4] = 4'(v % 32'sd10);
            v = v / 32'sd10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// -----------------------------------------------------------------------------
// bcd_seg7_decoder
// Converts one BCD digit into active-low seven-segment drive, DP always off.
// Ports:
//   digit : input  4-bit BCD value
//   blank : input  1 forces all segments off
//   seg   : output 8-bit active-low segments {DP,G,F,E,D,C,B,A}
// Non-BCD inputs (10..15) show blank.
// -----------------------------------------------------------------------------
module bcd_seg7_decoder
    import score_pkg::*;
(
    input  bcd_digit_t  digit,
    input  logic        blank,
    output logic [7:0]  seg
);

    // Digit-to-segment lookup with blank override.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
// BCD score counter with sticky win flag and multiplexed seven-segment display.
// Ports:
//   CLK        : input  clock, all state on rising edge
//   RESET      : input  synchronous active-high reset
//   REACHED    : input  rising edge adds one point
//   PENALTY    : input  rising edge removes one point (floor at zero)
//   WIN        : output sticky, high once SCORE equals WIN_SCORE
//   SCORE      : output packed BCD score, units in [3:0]
//   SEG_SELECT : output active-low one-hot digit select
//   HEX_OUT    : output active-low segments {DP,G,F,E,D,C,B,A}
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most
// significant non-zero digit (digit 0 always shown).
// -----------------------------------------------------------------------------
module score_tracker
    import score_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int WIN_SCORE   = 10,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    REACHED,
    input  logic                    PENALTY,
    output logic                    WIN,
    output logic [4*NUM_DIGITS-1:0] SCORE,
    output logic [3:0]              SEG_SELECT,
    output logic [7:0]              HEX_OUT
);

    localparam int              SW          = 4 * NUM_DIGITS;
    localparam logic [15:0]     WIN_BCD_ALL = win_to_bcd(WIN_SCORE);
    localparam logic [SW-1:0]   WIN_BCD     = WIN_BCD_ALL[SW-1:0];
    localparam int              CNT_W       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]      IDX_LAST    = 2'(NUM_DIGITS - 1);

    logic              reached_q, reached_d, penalty_q, penalty_d;
    logic              reached_blk_q, reached_blk_d, penalty_blk_q, penalty_blk_d;
    logic [SW-1:0]     score_q, score_d, score_inc_s, score_dec_s;
    logic              inc_carry_s, dec_borrow_s;
    logic              win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        seg_sel_q, seg_sel_d;
    logic [7:0]        hex_q, hex_d, dec_seg_s;
    logic              inc_ev_s, dec_ev_s;
    logic [15:0]       score_pad_s;
    bcd_digit_t        cur_digit_s;
    logic              blank_s;

    // Edge detection. The *_blk flags hold off an input that was already high
    // when reset was applied until it has been seen low once.
    always_comb begin
        reached_d     = REACHED;
        penalty_d     = PENALTY;
        reached_blk_d = reached_blk_q & REACHED;
        penalty_blk_d = penalty_blk_q & PENALTY;
        inc_ev_s      = REACHED & ~reached_q & ~reached_blk_q;
        dec_ev_s      = PENALTY & ~penalty_q & ~penalty_blk_q;
    end

    // Decimal increment and decrement candidates (ripple carry / borrow).
    always_comb begin
        score_inc_s  = score_q;
        score_dec_s  = score_q;
        inc_carry_s  = 1'b1;
        dec_borrow_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (inc_carry_s && (score_q[4*i +: 4] == 4'd9)) begin
                score_inc_s[4*i +: 4] = 4'd0;
            end else if (inc_carry_s) begin
                score_inc_s[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                inc_carry_s = 1'b0;
            end else begin
                score_inc_s[4*i +: 4] = score_q[4*i +: 4];
            end
            if (dec_borrow_s && (score_q[4*i +: 4] == 4'd0)) begin
                score_dec_s[4*i +: 4] = 4'd9;
            end else if (dec_borrow_s) begin
                score_dec_s[4*i +: 4] = score_q[4*i +: 4] - 4'd1;
                dec_borrow_s = 1'b0;
            end else begin
                score_dec_s[4*i +: 4] = score_q[4*i +: 4];
            end
        end
        // Decrement at zero saturates instead of wrapping to all nines.
        if (score_q == {SW{1'b0}}) begin
            score_dec_s = {SW{1'b0}};
        end else begin
            score_dec_s = score_dec_s;
        end
    end

    // Score and win next state; a won game freezes the score.
    always_comb begin
        score_d = score_q;
        if (win_q) begin
            score_d = score_q;
        end else if (inc_ev_s && !dec_ev_s) begin
            score_d = score_inc_s;
        end else if (dec_ev_s && !inc_ev_s) begin
            score_d = score_dec_s;
        end else begin
            score_d = score_q;
        end
        win_d = win_q | (score_d == WIN_BCD);
    end

    // Refresh divider and digit index.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = (idx_q == IDX_LAST) ? 2'd0 : (idx_q + 2'd1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Current digit selection and optional leading-zero blanking.
    always_comb begin
        score_pad_s = 16'(score_q);
        cur_digit_s = score_pad_s[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank_s = (idx_q != 2'd0) && ((score_pad_s >> {idx_q, 2'b00}) == 16'h0000);
`else
        blank_s = 1'b0;
`endif
        seg_sel_d = ~(4'b0001 << idx_q);
        hex_d     = dec_seg_s;
    end

    bcd_seg7_decoder u_decoder (
        .digit (cur_digit_s),
        .blank (blank_s),
        .seg   (dec_seg_s)
    );

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            reached_q     <= 1'b0;
            penalty_q     <= 1'b0;
            reached_blk_q <= REACHED;
            penalty_blk_q <= PENALTY;
            score_q       <= {SW{1'b0}};
            win_q         <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
            idx_q         <= 2'd0;
            seg_sel_q     <= 4'b1110;
            hex_q         <= SEG_0;
        end else begin
            reached_q     <= reached_d;
            penalty_q     <= penalty_d;
            reached_blk_q <= reached_blk_d;
            penalty_blk_q <= penalty_blk_d;
            score_q       <= score_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            seg_sel_q     <= seg_sel_d;
            hex_q         <= hex_d;
        end
    end

    assign WIN        = win_q;
    assign SCORE      = score_q;
    assign SEG_SELECT = seg_sel_q;
    assign HEX_OUT    = hex_q;

endmodule

// File: tb/tb_score_tracker.sv
// -----------------------------------------------------------------------------
// tb_score_tracker
// Self-checking bench for score_tracker (NUM_DIGITS=2, WIN_SCORE=60,
// REFRESH_DIV=4). A reference model computes the score as a plain integer and
// the display slot from the cycle count since reset.
// -----------------------------------------------------------------------------
module tb_score_tracker;

    localparam int ND  = 2;
    localparam int WS  = 60;
    localparam int DIV = 4;

    logic          CLK;
    logic          RESET;
    logic          REACHED;
    logic          PENALTY;
    logic          WIN;
    logic [7:0]    SCORE;
    logic [3:0]    SEG_SELECT;
    logic [7:0]    HEX_OUT;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_score;
    bit         m_win;
    bit         m_prev_r;
    bit         m_prev_p;
    int         m_k;
    logic [3:0] m_seg;
    logic [7:0] m_hex;

    logic [7:0] seg_codes [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    score_tracker #(
        .NUM_DIGITS  (ND),
        .WIN_SCORE   (WS),
        .REFRESH_DIV (DIV)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REACHED    (REACHED),
        .PENALTY    (PENALTY),
        .WIN        (WIN),
        .SCORE      (SCORE),
        .SEG_SELECT (SEG_SELECT),
        .HEX_OUT    (HEX_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int p10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Advance the reference model by one rising edge.
    task automatic model_step(input bit rst, input bit r, input bit p);
        int  old;
        int  idx;
        int  dig;
        bit  blank;
        bit  evr;
        bit  evp;
        if (rst) begin
            m_score = 0;
            m_win   = 1'b0;
            m_k     = 0;
            m_seg   = 4'b1110;
            m_hex   = 8'hC0;
        end else begin
            old   = m_score;
            m_k   = m_k + 1;
            idx   = ((m_k - 1) / DIV) % ND;
            m_seg = 4'hF & ~(4'b0001 << idx);
            dig   = (old / p10(idx)) % 10;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (idx > 0) && (old < p10(idx));
`endif
            m_hex = blank ? 8'hFF : seg_codes[dig];
            evr = r && !m_prev_r;
            evp = p && !m_prev_p;
            if (!m_win) begin
                if (evr && !evp) m_score = (m_score + 1) % p10(ND);
                else if (evp && !evr && m_score > 0) m_score = m_score - 1;
            end
            if (m_score == WS) m_win = 1'b1;
        end
        m_prev_r = r;
        m_prev_p = p;
    endtask

    // Drive one cycle at the falling edge, clock it, return at the next falling edge.
    task automatic step(input bit rst, input bit r, input bit p);
        RESET   = rst;
        REACHED = r;
        PENALTY = p;
        @(posedge CLK);
        model_step(rst, r, p);
        @(negedge CLK);
    endtask

    task automatic pulse_r(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (SCORE !== 8'h00) begin errors++; $display("FAIL reset_score got %h exp 00", SCORE); end
        checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL reset_win got %b exp 0", WIN); end
        checks++; if (SEG_SELECT !== 4'b1110) begin errors++; $display("FAIL reset_seg got %b exp 1110", SEG_SELECT); end
        checks++; if (HEX_OUT !== 8'hC0) begin errors++; $display("FAIL reset_hex got %h exp C0", HEX_OUT); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold_and_win();
        step(1'b0, 1'b1, 1'b0);
        checks++; if (SCORE !== 8'h01) begin errors++; $display("FAIL hold_first got %h exp 01", SCORE); end
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
        checks++; if (SCORE !== 8'h01) begin errors++; $display("FAIL hold_once got %h exp 01", SCORE); end
        step(1'b0, 1'b0, 1'b0);
        pulse_r(58);
        checks++; if (SCORE !== 8'h59 || WIN !== 1'b0) begin errors++; $display("FAIL pre_win got %h/%b exp 59/0", SCORE, WIN); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (SCORE !== 8'h60 || WIN !== 1'b1) begin errors++; $display("FAIL win_edge got %h/%b exp 60/1", SCORE, WIN); end
        step(1'b0, 1'b0, 1'b0);
        pulse_r(1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (SCORE !== 8'h60 || WIN !== 1'b1) begin errors++; $display("FAIL win_frozen got %h/%b exp 60/1", SCORE, WIN); end
    endtask

    task automatic test_carry_borrow();
        do_reset();
        pulse_r(9);
        checks++; if (SCORE !== 8'h09) begin errors++; $display("FAIL count9 got %h exp 09", SCORE); end
        pulse_r(1);
        checks++; if (SCORE !== 8'h10) begin errors++; $display("FAIL carry got %h exp 10", SCORE); end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (SCORE !== 8'h09) begin errors++; $display("FAIL borrow got %h exp 09", SCORE); end
    endtask

    task automatic test_floor_and_simul();
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (SCORE !== 8'h00) begin errors++; $display("FAIL floor got %h exp 00", SCORE); end
        pulse_r(5);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (SCORE !== 8'h05) begin errors++; $display("FAIL simul got %h exp 05", SCORE); end
    endtask

    task automatic test_display();
        int seen0;
        int seen1;
        logic [7:0] exp_hi;
        seen0 = 0;
        seen1 = 0;
`ifdef LEADING_ZERO_BLANK_EN
        exp_hi = 8'hFF;
`else
        exp_hi = 8'hC0;
`endif
        do_reset();
        pulse_r(7);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (SEG_SELECT !== m_seg || HEX_OUT !== m_hex) begin
                errors++;
                $display("FAIL disp_model got %b/%h exp %b/%h", SEG_SELECT, HEX_OUT, m_seg, m_hex);
            end
            if (SEG_SELECT === 4'b1110) begin
                seen0++;
                checks++; if (HEX_OUT !== 8'hF8) begin errors++; $display("FAIL disp_d0 got %h exp F8", HEX_OUT); end
            end else if (SEG_SELECT === 4'b1101) begin
                seen1++;
                checks++; if (HEX_OUT !== exp_hi) begin errors++; $display("FAIL disp_d1 got %h exp %h", HEX_OUT, exp_hi); end
            end else begin
                checks++; errors++;
                $display("FAIL disp_sel got %b exp 1110 or 1101", SEG_SELECT);
            end
        end
        checks++; if (seen0 != 8 || seen1 != 8) begin errors++; $display("FAIL disp_split got %0d/%0d exp 8/8", seen0, seen1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_r(42);
        checks++; if (SCORE !== 8'h42) begin errors++; $display("FAIL mid_pre got %h exp 42", SCORE); end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++; if (SCORE !== 8'h00) begin errors++; $display("FAIL mid_reset got %h exp 00", SCORE); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        checks++; if (SCORE !== 8'h00) begin errors++; $display("FAIL mid_held got %h exp 00", SCORE); end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++; if (SCORE !== 8'h01) begin errors++; $display("FAIL mid_after got %h exp 01", SCORE); end
    endtask

    task automatic test_random();
        bit rst;
        bit r;
        bit p;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            r   = ($urandom_range(0, 2) != 0);
            p   = ($urandom_range(0, 3) == 0);
            step(rst, r, p);
            checks++;
            if (SCORE !== to_bcd(m_score) || WIN !== m_win) begin
                errors++;
                $display("FAIL rand_score cyc %0d got %h/%b exp %h/%b", i, SCORE, WIN, to_bcd(m_score), m_win);
            end
            checks++;
            if (SEG_SELECT !== m_seg || HEX_OUT !== m_hex) begin
                errors++;
                $display("FAIL rand_disp cyc %0d got %b/%h exp %b/%h", i, SEG_SELECT, HEX_OUT, m_seg, m_hex);
            end
        end
    endtask

    initial begin
        RESET    = 1'b1;
        REACHED  = 1'b0;
        PENALTY  = 1'b0;
        m_score  = 0;
        m_win    = 1'b0;
        m_prev_r = 1'b0;
        m_prev_p = 1'b0;
        m_k      = 0;
        m_seg    = 4'b1110;
        m_hex    = 8'hC0;
        @(negedge CLK);
        test_reset();
        test_hold_and_win();
        test_carry_borrow();
        test_floor_and_simul();
        test_display();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
